// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 scanning multiplexer.
package mux_pkg;

  // Operating state, derived each cycle from mode/hold.
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Board LED bank width.
  localparam int LED_W = 10;

  // One second per channel at a 50 MHz system clock.
  localparam int unsigned DWELL_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles and pulses tick on the last cycle of
// each DWELL-cycle window, then wraps to zero.
import mux_pkg::*;

module dwell_timer #(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // Wide enough to hold DWELL-1 even at the top of the legal range.
  localparam int CW = $clog2(64'(DWELL) + 64'd1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 32'd1);

  logic [CW-1:0] count;

  // Clear has priority so a mode entry never produces a stray tick.
  assign tick = en && !clr && (count == LAST);

  // Count enabled cycles, wrapping at DWELL-1; frozen when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-channel, W-bit registered multiplexer with manual select, round-robin
// auto-scan with programmable dwell, scan hold and a channel-change strobe.
import mux_pkg::*;

module mux_nto1_scan #(
  parameter int          N     = 4,
  parameter int          W     = 1,
  parameter int unsigned DWELL = DWELL_DEFAULT,
  localparam int         SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   c,
  input  logic [SW-1:0]    sel,
  input  logic             mode,
  input  logic             hold,
  output logic [W-1:0]     z,
  output logic [SW-1:0]    active_ch,
  output logic             ch_change,
  output logic [LED_W-1:0] LEDR
);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] sel_safe;
  logic [SW-1:0] ch_next;
  logic [W-1:0]  z_next;
  logic          timer_en;
  logic          timer_clr;
  logic          tick;

  // Selects beyond the last channel (non power-of-two N) fall back to 0.
  assign sel_safe = (int'(sel) < N) ? sel : '0;

  // The mode/hold inputs decide this edge's behaviour; the registered state
  // only tells us whether we are leaving MANUAL. Leaving or staying in MANUAL
  // clears the count, so a mode change always beats a dwell expiry.
  assign state_next = mode ? (hold ? HOLD : SCAN) : MANUAL;
  assign timer_clr  = (state_next == MANUAL) || (state == MANUAL);
  assign timer_en   = (state_next == SCAN) && (state != MANUAL);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (timer_en),
    .clr   (timer_clr),
    .tick  (tick)
  );

  // Next channel and data: manual follows sel, scan advances on tick, hold
  // freezes the channel while data keeps tracking the live input.
  always_comb begin
    ch_next = active_ch;
    z_next  = c[int'(active_ch)*W +: W];
    unique case (state_next)
      MANUAL: begin
        ch_next = sel_safe;
        z_next  = c[int'(sel_safe)*W +: W];
      end
      SCAN: begin
        if (tick) begin
          ch_next = (active_ch == SW'(N - 1)) ? '0 : active_ch + SW'(1);
        end
      end
      HOLD: begin
        ch_next = active_ch;
      end
      default: begin
        ch_next = active_ch;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
    end else begin
      state <= state_next;
    end
  end

  // Output registers; ch_change rises on the same edge active_ch updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      active_ch <= '0;
      ch_change <= 1'b0;
    end else begin
      z         <= z_next;
      active_ch <= ch_next;
      ch_change <= (ch_next != active_ch);
    end
  end

  // LED bank mirrors z in the low bits; unused LEDs stay dark.
  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
    if (gi < W) begin : g_on
      assign LEDR[gi] = z[gi];
    end else begin : g_off
      assign LEDR[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: two instances (N=4/W=1 and N=3/W=4, both
// DWELL=3) driven from one linear sequence; expectations go into a scoreboard
// queue before each clock edge and are compared just after it.
module tb_mux_nto1_scan;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        hold;

  logic [3:0]  a_c;
  logic [1:0]  a_sel;
  logic [0:0]  a_z;
  logic [1:0]  a_ch;
  logic        a_chg;
  logic [9:0]  a_led;

  logic [11:0] b_c;
  logic [1:0]  b_sel;
  logic [3:0]  b_z;
  logic [1:0]  b_ch;
  logic        b_chg;
  logic [9:0]  b_led;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  mux_nto1_scan #(.N(4), .W(1), .DWELL(3)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (a_c),
    .sel       (a_sel),
    .mode      (mode),
    .hold      (hold),
    .z         (a_z),
    .active_ch (a_ch),
    .ch_change (a_chg),
    .LEDR      (a_led)
  );

  mux_nto1_scan #(.N(3), .W(4), .DWELL(3)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (b_c),
    .sel       (b_sel),
    .mode      (1'b0),
    .hold      (1'b0),
    .z         (b_z),
    .active_ch (b_ch),
    .ch_change (b_chg),
    .LEDR      (b_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "a_z":   return 32'(a_z);
      "a_ch":  return 32'(a_ch);
      "a_chg": return 32'(a_chg);
      "a_led": return 32'(a_led);
      "b_z":   return 32'(b_z);
      "b_ch":  return 32'(b_ch);
      "b_chg": return 32'(b_chg);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    logic [3:0] scan_c;
    rst_n = 1'b0;
    mode  = 1'b0;
    hold  = 1'b0;
    a_c   = 4'b0110;
    a_sel = 2'd0;
    b_c   = {4'hC, 4'hB, 4'hA};
    b_sel = 2'd0;

    // Reset state, observed before any clock edge.
    #3;
    push("a_z", 0); push("a_ch", 0); push("a_chg", 0); push("a_led", 0);
    push("b_z", 0); push("b_ch", 0);
    drain();
    tick();
    rst_n = 1'b1;

    // Manual select with sel=0: no channel change out of reset.
    push("a_ch", 0); push("a_chg", 0); push("a_z", 0);
    tick();

    // Manual sel=2 -> z=c[2]=1 one cycle later, single ch_change pulse.
    a_sel = 2'd2;
    push("a_z", 1); push("a_ch", 2); push("a_chg", 1); push("a_led", 10'b0000000001);
    tick();
    push("a_ch", 2); push("a_chg", 0);
    tick();

    // Data change on the selected channel reaches z after one clock.
    a_c = 4'b1011;
    push("a_z", 0); push("a_led", 0);
    tick();

    // Out-of-range select on the 3-channel instance falls back to channel 0.
    b_sel = 2'd3;
    push("b_z", 4'hA); push("b_ch", 0);
    tick();
    b_sel = 2'd2;
    push("b_z", 4'hC); push("b_ch", 2); push("b_chg", 1);
    tick();

    // Back to channel 0 before scanning.
    a_sel = 2'd0;
    push("a_ch", 0); push("a_chg", 1); push("a_z", 1);
    tick();

    // Scan: entry edge k=0, advance every 3 edges, wrap 3 -> 0 at k=12.
    scan_c = 4'b0110;
    a_c    = scan_c;
    mode   = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      push("a_ch", 32'((k / 3) % 4));
      push("a_chg", (k > 0 && k % 3 == 0) ? 32'd1 : 32'd0);
      push("a_z", 32'(scan_c[(k == 0) ? 0 : ((k - 1) / 3) % 4]));
      tick();
    end

    // Hold for 5 cycles on channel 1 (one cycle already counted there).
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_c[1] = ~a_c[1];
      push("a_ch", 1); push("a_chg", 0); push("a_z", 32'(a_c[1]));
      tick();
    end

    // Release: count resumes at 1, so the advance lands two edges later.
    hold = 1'b0;
    push("a_ch", 1); push("a_chg", 0);
    tick();
    push("a_ch", 2); push("a_chg", 1);
    tick();

    // Two more cycles on channel 2; the third would expire the dwell.
    push("a_ch", 2); push("a_chg", 0);
    tick();
    push("a_ch", 2); push("a_chg", 0);
    tick();

    // Leave scan on the expiry edge: sel wins, no advance to channel 3.
    mode  = 1'b0;
    a_sel = 2'd1;
    push("a_ch", 1); push("a_chg", 1);
    tick();

    // Re-enter scan on channel 1, then reset mid-dwell.
    a_c  = 4'b1111;
    mode = 1'b1;
    push("a_ch", 1); push("a_z", 1);
    tick();
    push("a_ch", 1); push("a_z", 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push("a_z", 0); push("a_ch", 0); push("a_chg", 0); push("a_led", 0);
    drain();
    push("a_ch", 0); push("a_z", 0);
    tick();
    rst_n = 1'b1;

    // Scan restarts at channel 0 and first advances after DWELL edges.
    for (int k = 0; k <= 3; k++) begin
      push("a_ch", (k == 3) ? 32'd1 : 32'd0);
      push("a_chg", (k == 3) ? 32'd1 : 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
